// File: rtl/robber_language_pkg.sv
// Shared constants, FSM state types and the consonant test for the robber-language codec.
package robber_language_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CH_LO_O   = 8'h6F;
  localparam logic [BYTE_W-1:0] CH_UP_O   = 8'h4F;
  localparam logic [BYTE_W-1:0] CH_LO_Y   = 8'h79;
  localparam logic [BYTE_W-1:0] CASE_BIT  = 8'h20;
  localparam logic [BYTE_W-1:0] CH_LO_A   = 8'h61;
  localparam logic [BYTE_W-1:0] CH_LO_Z   = 8'h7A;
  localparam logic [5*BYTE_W-1:0] VOWEL_SET = {8'h61, 8'h65, 8'h69, 8'h6F, 8'h75};

  typedef enum logic [1:0] {E_IDLE, E_EMIT_O, E_EMIT_C} enc_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXP_O, D_EXP_C} dec_state_t;

  // Folding to lowercase maps exactly A-Z and a-z onto a-z, nothing else lands there.
  function automatic logic is_consonant(input logic [BYTE_W-1:0] ch, input logic y_is_vowel);
    logic [BYTE_W-1:0] lc;
    logic              res;
    lc  = ch | CASE_BIT;
    res = (lc >= CH_LO_A) && (lc <= CH_LO_Z);
    for (int i = 0; i < 5; i++) begin
      if (lc == VOWEL_SET[BYTE_W*i +: BYTE_W]) res = 1'b0;
    end
    if (y_is_vowel && (lc == CH_LO_Y)) res = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/robber_char_class.sv
// Combinational byte classifier: consonant flag and the vowel to insert after it.
// Build option ROBBER_UPPER_O_EN makes the inserted vowel follow the consonant's case.
module robber_char_class
  import robber_language_pkg::*;
#(
  parameter int unsigned Y_IS_VOWEL = 1
) (
  input  logic [7:0] ch,
  output logic       cons_c,
  output logic [7:0] vowel_c
);

  assign cons_c = is_consonant(ch, 1'(Y_IS_VOWEL != 0));

`ifdef ROBBER_UPPER_O_EN
  assign vowel_c = ch[5] ? CH_LO_O : CH_UP_O;
`else
  assign vowel_c = CH_LO_O;
`endif

endmodule

// File: rtl/robber_language.sv
// Streaming rövarspråket encoder/decoder, one byte per cycle with busy backpressure.
// Optional build macro: ROBBER_UPPER_O_EN (case-matched inserted vowel).
module robber_language
  import robber_language_pkg::*;
#(
  parameter int unsigned Y_IS_VOWEL = 1
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  input  logic       init,
  input  logic       encdec,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_out_valid
);

  enc_state_t e_state, e_next;
  dec_state_t d_state, d_next;
  logic [7:0] saved, saved_next;
  logic [7:0] ins_vowel, ins_vowel_next;
  logic [7:0] out_next;
  logic       valid_next, busy_next, emit;
  logic       accept, cons_c, is_o, match_saved;
  logic [7:0] vowel_c;

  robber_char_class #(.Y_IS_VOWEL(Y_IS_VOWEL)) u_class (
    .ch      (data_in),
    .cons_c  (cons_c),
    .vowel_c (vowel_c)
  );

  assign accept      = data_in_valid && !busy && !init;
  assign is_o        = (data_in == CH_LO_O) || (data_in == CH_UP_O);
  assign match_saved = ((data_in | CASE_BIT) == (saved | CASE_BIT));

  // State and output registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      e_state        <= E_IDLE;
      d_state        <= D_IDLE;
      saved          <= 8'h00;
      ins_vowel      <= 8'h00;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      e_state        <= e_next;
      d_state        <= d_next;
      saved          <= saved_next;
      ins_vowel      <= ins_vowel_next;
      data_out       <= out_next;
      data_out_valid <= valid_next;
      busy           <= busy_next;
    end
  end

  // Next state and next registered outputs for both FSMs.
  always_comb begin
    e_next         = e_state;
    d_next         = d_state;
    saved_next     = saved;
    ins_vowel_next = ins_vowel;
    out_next       = data_out;
    valid_next     = 1'b0;
    emit           = 1'b0;
    if (init) begin
      e_next = E_IDLE;
      d_next = D_IDLE;
    end else begin
      case (e_state)
        E_EMIT_O: begin
          out_next   = ins_vowel;
          valid_next = 1'b1;
          e_next     = E_EMIT_C;
        end
        E_EMIT_C: begin
          out_next   = saved;
          valid_next = 1'b1;
          e_next     = E_IDLE;
        end
        default: begin
          if (accept && encdec) begin
            d_next     = D_IDLE;
            out_next   = data_in;
            valid_next = 1'b1;
            if (cons_c) begin
              saved_next     = data_in;
              ins_vowel_next = vowel_c;
              e_next         = E_EMIT_O;
            end
          end else if (accept) begin
            // A broken pattern falls back to treating the byte as fresh input.
            emit = 1'b1;
            case (d_state)
              D_EXP_O: if (is_o) begin
                emit   = 1'b0;
                d_next = D_EXP_C;
              end
              D_EXP_C: if (match_saved) begin
                emit   = 1'b0;
                d_next = D_IDLE;
              end
              default: ;
            endcase
            if (emit) begin
              out_next   = data_in;
              valid_next = 1'b1;
              if (cons_c) begin
                saved_next = data_in;
                d_next     = D_EXP_O;
              end else begin
                d_next = D_IDLE;
              end
            end
          end
        end
      endcase
    end
    busy_next = (e_next != E_IDLE);
  end

endmodule

// File: tb/tb_robber_language.sv
// Self-checking bench for robber_language: vector table plus scoreboard, and hand sequences.
module tb_robber_language;

  logic       clk = 1'b0;
  logic       reset_l, init, encdec, data_in_valid;
  logic [7:0] data_in;
  logic       busy, data_out_valid, y_busy, y_valid;
  logic [7:0] data_out, y_out;

  always #5 clk = ~clk;

  robber_language dut (
    .clk(clk), .reset_l(reset_l), .data_in(data_in), .data_in_valid(data_in_valid),
    .init(init), .encdec(encdec), .busy(busy), .data_out(data_out),
    .data_out_valid(data_out_valid)
  );

  robber_language #(.Y_IS_VOWEL(0)) dut_y0 (
    .clk(clk), .reset_l(reset_l), .data_in(data_in), .data_in_valid(data_in_valid),
    .init(init), .encdec(encdec), .busy(y_busy), .data_out(y_out),
    .data_out_valid(y_valid)
  );

  typedef struct packed {
    logic [63:0] in_s;
    logic [3:0]  in_n;
    logic        enc;
    logic [63:0] exp_s;
    logic [3:0]  exp_n;
  } vec_t;

  vec_t       vecs [8];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  logic [7:0] expq [$];
  int         vcyc [$];

  function automatic bit tb_cons(input logic [7:0] b);
    logic [7:0] l;
    l = b | 8'h20;
    if (!((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))) return 1'b0;
    if (l == 8'h61 || l == 8'h65 || l == 8'h69 || l == 8'h6F || l == 8'h75 || l == 8'h79)
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Advance to the next falling edge and score any emitted byte.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (data_out_valid) begin
      vcyc.push_back(cyc);
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %02h required no output", data_out);
      end else begin
        e = expq.pop_front();
        check("out_byte", int'(data_out), int'(e));
      end
    end
  endtask

  task automatic push_str(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) expq.push_back(s[8*(n-1-i) +: 8]);
  endtask

  task automatic send(input logic [7:0] b, input logic enc);
    int n;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    if (busy) check("send_busy_timeout", 1, 0);
    data_in       = b;
    encdec        = enc;
    data_in_valid = 1'b1;
    tick();
  endtask

  task automatic drain();
    data_in_valid = 1'b0;
    for (int i = 0; i < 12 && expq.size() != 0; i++) tick();
    repeat (3) tick();
    check("drain_left", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0; init = 1'b0; encdec = 1'b1; data_in = 8'h00; data_in_valid = 1'b0;

    vecs[0] = '{64'("hej"),     4'd3, 1'b1, 64'("hohejoj"), 4'd7};
    vecs[1] = '{64'("a 5"),     4'd3, 1'b1, 64'("a 5"),     4'd3};
    vecs[2] = '{64'("hohejoj"), 4'd7, 1'b0, 64'("hej"),     4'd3};
    vecs[3] = '{64'("BOb"),     4'd3, 1'b0, 64'("B"),       4'd1};
    vecs[4] = '{64'("bx"),      4'd2, 1'b0, 64'("bx"),      4'd2};
    vecs[5] = '{64'("bod"),     4'd3, 1'b0, 64'("bd"),      4'd2};
`ifdef ROBBER_UPPER_O_EN
    vecs[6] = '{64'("T"),       4'd1, 1'b1, 64'("TOT"),     4'd3};
`else
    vecs[6] = '{64'("T"),       4'd1, 1'b1, 64'("ToT"),     4'd3};
`endif
    vecs[7] = '{64'("Y!z"),     4'd3, 1'b1, 64'("Y!zoz"),   4'd5};

    repeat (2) @(negedge clk);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid", int'(data_out_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset_l = 1'b1;
    tick();

    // Single consonant: exact per-cycle busy/valid.
    expq.push_back(8'h62); expq.push_back(8'h6F); expq.push_back(8'h62);
    data_in = 8'h62; encdec = 1'b1; data_in_valid = 1'b1;
    tick(); check("b_busy1", int'(busy), 1);
    data_in_valid = 1'b0;
    tick(); check("b_busy2", int'(busy), 1);
    tick(); check("b_busy3", int'(busy), 0); check("b_valid3", int'(data_out_valid), 1);
    tick(); check("b_valid4", int'(data_out_valid), 0);
    check("b_left", expq.size(), 0);

    for (int v = 0; v < 8; v++) begin
      int v0, b0, nb, n;
      logic [7:0] c;
      n = int'(vecs[v].exp_n);
      push_str(vecs[v].exp_s, n);
      v0 = vcyc.size(); b0 = busy_cnt; nb = 0;
      for (int i = 0; i < int'(vecs[v].in_n); i++) begin
        c = vecs[v].in_s[8*(int'(vecs[v].in_n)-1-i) +: 8];
        if (vecs[v].enc && tb_cons(c)) nb += 2;
        send(c, vecs[v].enc);
      end
      drain();
      check("vec_busy_cycles", busy_cnt - b0, nb);
      check("vec_out_count", vcyc.size() - v0, n);
      if (vecs[v].enc && vcyc.size() >= v0 + n)
        check("vec_gapfree", vcyc[v0+n-1] - vcyc[v0], n - 1);
    end

    // init one cycle into an expansion aborts it.
    expq.push_back(8'h6B);
    data_in = 8'h6B; encdec = 1'b1; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0; init = 1'b1;
    tick(); check("init_busy", int'(busy), 0); check("init_valid", int'(data_out_valid), 0);
    init = 1'b0;
    tick(); check("init_valid2", int'(data_out_valid), 0);
    expq.push_back(8'h61);
    send(8'h61, 1'b1);
    drain();

    // Input coinciding with init is dropped.
    data_in = 8'h71; encdec = 1'b1; data_in_valid = 1'b1; init = 1'b1;
    tick(); check("init_drop_valid", int'(data_out_valid), 0); check("init_drop_busy", int'(busy), 0);
    init = 1'b0; data_in_valid = 1'b0;
    drain();

    // init clears a pending decode pattern, so the following 'o' is emitted.
    expq.push_back(8'h62);
    send(8'h62, 1'b0);
    data_in_valid = 1'b0; init = 1'b1;
    tick();
    init = 1'b0;
    expq.push_back(8'h6F);
    send(8'h6F, 1'b0);
    drain();

    // Asynchronous reset during the vowel cycle.
    expq.push_back(8'h6D); expq.push_back(8'h6F);
    data_in = 8'h6D; encdec = 1'b1; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    tick();
    reset_l = 1'b0;
    #1;
    check("arst_data_out", int'(data_out), 0);
    check("arst_valid", int'(data_out_valid), 0);
    check("arst_busy", int'(busy), 0);
    #2 reset_l = 1'b1;
    repeat (4) tick();
    check("arst_left", expq.size(), 0);

    // y is a vowel by default but a consonant on the Y_IS_VOWEL=0 instance.
    expq.push_back(8'h79);
    data_in = 8'h79; encdec = 1'b1; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    check("y0_valid1", int'(y_valid), 1); check("y0_out1", int'(y_out), 8'h79);
    check("y0_busy1", int'(y_busy), 1);
    tick(); check("y0_out2", int'(y_out), 8'h6F); check("y0_valid2", int'(y_valid), 1);
    tick(); check("y0_out3", int'(y_out), 8'h79); check("y0_busy3", int'(y_busy), 0);
    tick(); check("y0_valid4", int'(y_valid), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/robber_language.md
Name: robber_language

Overview:
- Byte-stream codec for the Swedish "robber language" (rövarspråket).
- Encode mode: every ASCII consonant c is expanded to the three bytes c, 'o', c. All other bytes pass through unchanged.
- Decode mode: the expansion is collapsed back to a single consonant.
- Streaming block with a one-byte-per-cycle valid interface and a busy backpressure flag; sits between a byte source and a byte sink.

Parameters:
- Y_IS_VOWEL, default 1: 1 treats 'y'/'Y' as a vowel (passed through); 0 treats it as a consonant.

Ports:
- clk  in  1  clock, rising edge.
- reset_l  in  1  reset, asynchronous, active-low.
- data_in  in  8  input byte (ASCII).
- data_in_valid  in  1  input byte present.
- init  in  1  synchronous state clear, single-cycle pulse.
- encdec  in  1  mode: 1 = encode, 0 = decode; sampled on byte acceptance.
- busy  out  1  registered; 1 = input is not accepted this cycle.
- data_out  out  8  output byte, registered.
- data_out_valid  out  1  registered; data_out is valid this cycle.

Behaviour:
- Reset values: data_out=0x00, data_out_valid=0, busy=0, all FSMs idle, saved consonant=0x00.
- Consonant definition: A–Z or a–z, excluding AEIOU/aeiou, and excluding Y/y when Y_IS_VOWEL=1. Every other byte value is a non-consonant.
- Acceptance: a byte is accepted on a rising edge when data_in_valid=1, busy=0 and init=0.
- Holding data: the source must hold data_in while busy=1. data_in_valid during busy is ignored, not queued.
- Encode, non-consonant accepted at edge k: data_out=byte with valid=1 in cycle k+1. Latency 1, busy stays 0.
- Encode, consonant accepted at edge k:
  - Output c in cycle k+1, 'o' in k+2, c in k+3.
  - busy=1 in cycles k+1 and k+2.
  - The next byte can be accepted at edge k+3, so streaming is gap-free.
- Decode FSM states:
  - D_IDLE: accepted consonant → output it, save it, go to D_EXP_O. Non-consonant → output it, stay in D_IDLE.
  - D_EXP_O: 'o' or 'O' → no output, go to D_EXP_C. Any other byte → abandon the pattern and process the byte as in D_IDLE.
  - D_EXP_C: byte equals the saved consonant (case-insensitive) → no output, go to D_IDLE. Otherwise the 'o' is lost; process the byte as in D_IDLE.
  - Decode never asserts busy. Latency 1 for emitted bytes.
- data_out_valid is 0 in every cycle without an emitted byte. data_out holds its last value.
- Accepting a byte with encdec=1 forces the decode FSM to D_IDLE.
- Changing encdec during an encode expansion has no effect on that expansion.
- init=1 at an edge (highest priority after reset):
  - Aborts any expansion, returns both FSMs to idle.
  - Next cycle: busy=0 and data_out_valid=0.
  - Input on the same edge is dropped.
- Asynchronous reset mid-expansion: immediate return to reset values; no remaining bytes are emitted.

Optional Feature:
- ROBBER_UPPER_O_EN defined: the inserted vowel matches the consonant's case ('B' → "BOB", 'b' → "bob").
- Not defined: the inserted vowel is always lowercase 'o' ('B' → "BoB").
- Decode accepts 'o' and 'O' in both builds.

Decomposition:
- Package robber_language_pkg:
  - ASCII constants: 'o', 'O', the vowel set.
  - Encode FSM enum: E_IDLE, E_EMIT_O, E_EMIT_C.
  - Decode FSM enum: D_IDLE, D_EXP_O, D_EXP_C.
  - Function is_consonant(byte, y_is_vowel).
- Optional sub-module robber_char_class: purely combinational consonant/uppercase classifier. Everything else stays in one module.

Test Plan:
- Encode 'b' (0x62), encdec=1 → outputs 0x62,0x6F,0x62 on three consecutive cycles; busy=1 for two cycles.
- Encode stream "hej" held per busy → outputs "hohejoj" with no valid gaps. Encode 'a', ' ', '5' → passed through at 1-cycle latency, busy never set.
- Decode "hohejoj" with encdec=0 → outputs "hej", valid exactly 3 cycles; busy stays 0. Decode "BOb" → "B".
- Decode malformed "bx" → 'b','x'. Decode "bod" → 'b','d' (the 'o' is lost).
- init pulse one cycle after encoding 'k' → only 'k' is emitted, then valid=0, busy=0. A subsequent 'a' passes through.
- reset_l low during the 'o' cycle of an expansion → outputs zero immediately; no trailing consonant after release. With Y_IS_VOWEL=0, 'y' → "yoy". With ROBBER_UPPER_O_EN, 'T' → "TOT".
